// File: rtl/sysarr_mac_pipe.sv
// Pipelined signed multiply-accumulate PE with a stationary weight and LATENCY-cycle result timing.
// Optional feature: define SYSARR_MAC_SAT_EN to clamp overflowing sums instead of wrapping.
module sysarr_mac_pipe #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              MAC_shift,
  input  logic              start,
  input  logic [DATA_W-1:0] in_value,
  input  logic [DATA_W-1:0] weight,
  input  logic [ACC_W-1:0]  in_accumulate,
  output logic [DATA_W-1:0] out_value,
  output logic [ACC_W-1:0]  out_accumulate,
  output logic              value_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] weight_reg;
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] w_ext;
  logic [PROD_W-1:0] prod_in;

  // Operands of the final add stage, either straight from the inputs or from the delay line.
  logic              s_valid;
  logic [PROD_W-1:0] s_prod;
  logic [ACC_W-1:0]  s_acc;
  logic              busy_next;

  logic [ACC_W:0]    sum_full;
  logic [ACC_W-1:0]  sum_out;
  logic              sum_ovf;

  // The low PROD_W bits of the product of sign-extended operands are the exact signed product.
  assign a_ext   = {{DATA_W{in_value[DATA_W-1]}}, in_value};
  assign w_ext   = {{DATA_W{weight_reg[DATA_W-1]}}, weight_reg};
  assign prod_in = a_ext * w_ext;

  if (LATENCY == 1) begin : g_lat1
    assign s_valid   = start;
    assign s_prod    = prod_in;
    assign s_acc     = in_accumulate;
    assign busy_next = start;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld;
    logic [PROD_W-1:0]  prod_q [LATENCY-1];
    logic [ACC_W-1:0]   acc_q  [LATENCY-1];

    // NOTE: only the valid bits need reset; payload registers are qualified by them.
    always_ff @(posedge clk) begin
      if (!nRST) begin
        vld <= '0;
      end else begin
        vld[0] <= start;
        for (int i = 1; i < LATENCY - 1; i++) vld[i] <= vld[i-1];
      end
    end

    always_ff @(posedge clk) begin
      prod_q[0] <= prod_in;
      acc_q[0]  <= in_accumulate;
      for (int i = 1; i < LATENCY - 1; i++) begin
        prod_q[i] <= prod_q[i-1];
        acc_q[i]  <= acc_q[i-1];
      end
    end

    assign s_valid   = vld[LATENCY-2];
    assign s_prod    = prod_q[LATENCY-2];
    assign s_acc     = acc_q[LATENCY-2];
    // Everything that will still be in flight after this edge, including the result stage.
    assign busy_next = start | (|vld);
  end

  // NOTE: every variable written here gets a value first, so no latch can be inferred.
  always_comb begin
    sum_full = {s_acc[ACC_W-1], s_acc}
             + {{(ACC_W + 1 - PROD_W){s_prod[PROD_W-1]}}, s_prod};
    sum_ovf  = sum_full[ACC_W] ^ sum_full[ACC_W-1];
    sum_out  = sum_full[ACC_W-1:0];
`ifdef SYSARR_MAC_SAT_EN
    if (sum_ovf) begin
      sum_out = sum_full[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                : {1'b0, {(ACC_W - 1){1'b1}}};
    end
`endif
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      weight_reg     <= '0;
      out_value      <= '0;
      out_accumulate <= '0;
      overflow       <= 1'b0;
      value_ready    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      if (MAC_shift) weight_reg <= weight;
      if (start)     out_value  <= in_value;
      value_ready <= s_valid;
      busy        <= busy_next;
      if (s_valid) begin
        out_accumulate <= sum_out;
        overflow       <= sum_ovf;
      end
    end
  end

endmodule
